// File: rtl/instr_encoder.sv
// Instruction encoder/loader: validates field bundles, packs them into 32-bit words and writes them to instruction memory.
// Optional build macro ENC_ILLEGAL_TRAP_EN: the first illegal bundle aborts the session instead of being skipped.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_func,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [7:0]        illegal_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE  = 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [31:0]         r_wdata;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_cnt;

    logic                w_accept;
    logic                w_legal;
    logic                w_stop;
    logic [2:0]          w_func_eff;
    logic [31:0]         w_word;

    // Only the ALU (00000) and vector (11000) opcodes carry a function field.
    always_comb begin
        w_legal    = 1'b0;
        w_func_eff = 3'b000;
        case (in_opcode)
            5'b00000: begin
                w_legal    = (in_func <= 3'd5);
                w_func_eff = in_func;
            end
            5'b11000: begin
                w_legal    = (in_func <= 3'd3);
                w_func_eff = in_func;
            end
            5'b01000, 5'b01001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b10000, 5'b00110,
            5'b10001, 5'b01010, 5'b01011, 5'b11110,
            5'b11011, 5'b11101: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_word   = {in_opcode, w_func_eff, in_rd, in_rs1, in_rs2, in_imm};
    assign w_accept = in_valid && in_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
    assign w_stop = (r_remaining == REM_ONE) || !w_legal;
`else
    assign w_stop = (r_remaining == REM_ONE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (word_count != '0)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_stop) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Illegal bundles consume a count slot but leave the write address untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= word_count;
                        r_err       <= 1'b0;
                        r_cnt       <= '0;
                        r_done      <= (word_count == '0);
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - REM_ONE;
                        if (w_legal) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_addr;
                            r_wdata <= w_word;
                            r_addr  <= r_addr + ADDR_ONE;
                        end else begin
                            r_err <= 1'b1;
                            if (r_cnt != 8'hFF) begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign imem_we     = r_we;
    assign imem_addr   = r_waddr;
    assign imem_wdata  = r_wdata;
    assign done        = r_done;
    assign err_illegal = r_err;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed and random load sessions against a field-level reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [2:0]  in_func = '0;
    logic [3:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [11:0] in_imm = '0;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err_illegal;
    logic [7:0]  illegal_cnt;

    instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func(in_func), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0]  exp_addr[$];
    logic [31:0] exp_data[$];

    int b_op[64], b_fn[64], b_rd[64], b_rs1[64], b_rs2[64], b_imm[64];
    int legal_ops[16] = '{0, 8, 9, 2, 3, 4, 5, 16, 6, 17, 10, 11, 24, 30, 27, 29};

    int m_addr, m_cnt;
    bit m_err, m_stop;

    task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit is_legal(int op, int fn);
        bit found = 0;
        foreach (legal_ops[k]) if (legal_ops[k] == op) found = 1;
        if (!found) return 0;
        if (op == 0) return fn <= 5;
        if (op == 24) return fn <= 3;
        return 1;
    endfunction

    function automatic logic [31:0] pack(int i);
        int f;
        longint w;
        f = (b_op[i] == 0 || b_op[i] == 24) ? b_fn[i] : 0;
        w = longint'(b_op[i]) * 134217728 + f * 16777216 + b_rd[i] * 1048576
          + b_rs1[i] * 65536 + b_rs2[i] * 4096 + b_imm[i];
        return w[31:0];
    endfunction

    task automatic set_bundle(int i, int op, int fn, int rd, int rs1, int rs2, int imm);
        b_op[i] = op; b_fn[i] = fn; b_rd[i] = rd; b_rs1[i] = rs1; b_rs2[i] = rs2; b_imm[i] = imm;
    endtask

    task automatic model_accept(int i);
        logic [31:0] a;
        if (is_legal(b_op[i], b_fn[i])) begin
            a = m_addr;
            exp_addr.push_back(a[9:0]);
            exp_data.push_back(pack(i));
            m_addr = (m_addr + 1) % 1024;
        end else begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
`ifdef ENC_ILLEGAL_TRAP_EN
            m_stop = 1;
`endif
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(int i, bit gaps, output bit acc);
        in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_opcode = 5'(b_op[i]);
        in_func   = 3'(b_fn[i]);
        in_rd     = 4'(b_rd[i]);
        in_rs1    = 4'(b_rs1[i]);
        in_rs2    = 4'(b_rs2[i]);
        in_imm    = 12'(b_imm[i]);
        start     = gaps && ($urandom_range(0, 5) == 0);
        base_addr = 10'($urandom);
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc) model_accept(i);
        @(negedge clk);
    endtask

    task automatic begin_session(int base, int wc);
        logic [31:0] b, w;
        b = base; w = wc;
        start = 1'b1; base_addr = b[9:0]; word_count = w[10:0];
        m_addr = base; m_err = 0; m_cnt = 0; m_stop = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_session(int base, int wc, bit gaps);
        int i = 0;
        int budget = 0;
        bit acc;
        begin_session(base, wc);
        if (wc == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            @(negedge clk);
            check("zero_done_pulse", done, 0);
            $display("session base=0x%03h wc=0 done-only", base);
            return;
        end
        while (i < wc && !m_stop && budget < 2000) begin
            step(i, gaps, acc);
            if (acc) i++;
            budget++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (budget >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: accepted %0d of %0d bundles", i, wc);
        end
        check("flush_busy", busy, 1);
        check("flush_done", done, 0);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", in_ready, 0);
        check("err_illegal", err_illegal, m_err);
        check("illegal_cnt", illegal_cnt, m_cnt);
        check("writes_pending", exp_addr.size(), 0);
        $display("session base=0x%03h wc=%0d accepted=%0d err=%0d cnt=%0d", base, wc, i, m_err, m_cnt);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_addr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr=0x%03h data=0x%08h, no write required", imem_addr, imem_wdata);
            end else begin
                logic [9:0]  ea;
                logic [31:0] ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                check("write_addr", imem_addr, ea);
                check("write_data", imem_wdata, ed);
                $display("write addr=0x%03h data=0x%08h", imem_addr, imem_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        #3;
        check("rst_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wdata", imem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD, ADDI, JMP with func that must be masked
        set_bundle(0, 0, 0, 1, 2, 3, 0);
        set_bundle(1, 8, 0, 4, 5, 0, 5);
        set_bundle(2, 16, 7, 0, 0, 0, 12'h123);
        run_session(16, 3, 0);

        run_session(5, 0, 0);

        set_bundle(0, 9, 0, 1, 1, 1, 1);
        set_bundle(1, 10, 0, 2, 2, 2, 2);
        run_session(1023, 2, 0);

        set_bundle(0, 2, 0, 3, 4, 5, 6);
        set_bundle(1, 7, 0, 1, 1, 1, 1);
        set_bundle(2, 3, 0, 7, 8, 9, 10);
        set_bundle(3, 4, 0, 15, 14, 13, 12'hFFF);
        run_session(100, 4, 0);

        set_bundle(0, 24, 4, 1, 2, 3, 4);
        set_bundle(1, 0, 5, 5, 6, 7, 8);
        set_bundle(2, 24, 3, 9, 10, 11, 12);
        run_session(200, 3, 0);

        // Reset in the middle of a session with a pending bundle
        set_bundle(0, 31, 0, 0, 0, 0, 0);
        for (int k = 1; k < 10; k++) set_bundle(k, 5, 0, k, k, k, k);
        begin_session(300, 10);
        for (int k = 0; k < 3; k++) step(k, 0, acc);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", in_ready, 0);
        check("arst_we", imem_we, 0);
        check("arst_addr", imem_addr, 0);
        check("arst_wdata", imem_wdata, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err_illegal, 0);
        check("arst_cnt", illegal_cnt, 0);
        exp_addr.delete();
        exp_data.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) set_bundle(k, 11, 0, k, 0, k, 7 * k);
        run_session(50, 3, 0);

        for (int s = 0; s < 30; s++) begin
            int wc;
            wc = $urandom_range(1, 12);
            for (int k = 0; k < wc; k++) begin
                int op;
                op = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 15)] : $urandom_range(0, 31);
                set_bundle(k, op, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 4095));
            end
            run_session($urandom_range(0, 1023), wc, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
